command_bus_master: RTL and testbench
=====================================

Name: command_bus_master

Overview:
- Host-side transmitter for the GPU parallel command bus.
- Turns single-word write/read requests from an on-chip requester into chipSelect/commandClk/outputEnable strobes and drives the command and data pins with fixed setup, pulse and hold timing.
- For reads, it tristates the data pins, asserts outputEnable, samples the GPU's returned word and presents it on a response port.
- Used in the host bridge and as the bus master in GPU system benches.

Parameters:
- SETUP_CYCLES, 2, clk cycles chipSelect/command/data are stable before commandClk rises (>=1)
- PULSE_CYCLES, 2, clk cycles commandClk is held high (>=1)
- HOLD_CYCLES, 1, clk cycles command/data are held after commandClk falls (>=1)
- READ_CYCLES, 3, clk cycles outputEnable is asserted before the read sample (>=1)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- reqValid  in  1  request present
- reqReady  out  1  master accepts a request this cycle
- reqWrite  in  1  1 = write, 0 = read
- reqCommand  in  16  command word
- reqData  in  16  write data (ignored for reads)
- rspValid  out  1  one-cycle pulse: rspData holds a read result
- rspData  out  16  last read word
- busy  out  1  transaction in progress
- chipSelect  out  1  bus chip select, active-low
- outputEnable  out  1  bus read enable, active-low
- commandClk  out  1  command strobe; the GPU latches on its rising edge
- command  out  16  command pins
- dataInOut  inout  16  data pins; driven only during write phases

Behaviour:
- Interface: one clock (clk); rst is asynchronous and active-low. Assertion forces every output to its reset value immediately, including mid-transaction.
- Reset values:
  - chipSelect=1, outputEnable=1, commandClk=0
  - command=0, dataInOut=Z (drive enable 0)
  - reqReady=0 while rst low, then 1
  - rspValid=0, rspData=0, busy=0
- Handshake:
  - A request is accepted when reqValid && reqReady at a clk edge.
  - reqReady = (state==IDLE).
  - All request fields are captured into registers at accept; the requester may change them afterwards.
- State machine: IDLE, SETUP, STROBE, HOLD, READ, TURN. One down-counter, width $clog2(max param)+1, loaded on every state entry.
  - IDLE: chipSelect=1, commandClk=0, no drive. On accept -> SETUP.
  - SETUP (SETUP_CYCLES):
    - chipSelect=0; command=captured word.
    - Write: dataInOut driven with captured data.
    - Read: dataInOut tristated.
  - STROBE (PULSE_CYCLES): commandClk=1; all other outputs held.
  - HOLD (HOLD_CYCLES): commandClk=0; outputs held. Then a write -> IDLE; a read -> READ.
  - READ (READ_CYCLES):
    - outputEnable=0, dataInOut tristated.
    - On the final cycle, dataInOut is registered into rspData and rspValid pulses high on the next cycle.
    - -> TURN.
  - TURN (1 cycle): outputEnable=1, chipSelect=0, no drive (bus turnaround), then -> IDLE.
- IDLE lasts at least one cycle between transactions, so chipSelect deasserts for >=1 cycle. Back-to-back requests keep reqValid high and are accepted on the first IDLE cycle.
- Latency from accept:
  - Write: chipSelect returns high after SETUP+PULSE+HOLD cycles (5 at defaults).
  - Read: rspValid rises SETUP+PULSE+HOLD+READ+1 cycles after accept (9 at defaults).
- All bus outputs are registered (no glitches). The data-pin drive enable is never high while outputEnable=0.
- busy = (state!=IDLE).
- rspData holds its value until the next read completes. Writes do not alter rspData.
- reqValid during non-IDLE states is ignored: no accept, no queueing.

Decomposition:
- Shared package cmd_bus_pkg:
  - state encoding enum
  - CMD_WIDTH=16, DATA_WIDTH=16
  - active-low level constants for chipSelect and outputEnable
- One natural sub-module, bus_phase_timer: loadable down-counter with a terminal-count flag. Reused for every phase.
- Tristate buffer kept in the top level.

Test Plan:
- Write: reqCommand=0x0012, reqData=0xBEEF, defaults -> chipSelect low for 5 cycles; commandClk high on cycles 3-4; dataInOut=0xBEEF and command=0x0012 stable from cycle 1 through cycle 5; reqReady low for 5 cycles.
- Read: reqCommand=0x8003, bench model drives 0x5A5A while outputEnable=0 -> dataInOut undriven by the master throughout; outputEnable low 3 cycles; rspValid pulses once with rspData=0x5A5A, 9 cycles after accept.
- Back-to-back writes 0x0001/0x1111 then 0x0002/0x2222 with reqValid held high -> exactly two commandClk rising edges; chipSelect high for exactly 1 cycle between them.
- Write then read then write -> rspData changes only after the read; no cycle where the master drives the pins while outputEnable=0.
- rst pulled low during STROBE of a write -> same cycle: commandClk=0, chipSelect=1, data tristated, busy=0; after release a new request is accepted on the first edge.
- Params SETUP=1, PULSE=1, HOLD=1, READ=1 -> write occupies 3 cycles; read rspValid arrives 5 cycles after accept.

Source files
------------

// File: rtl/cmd_bus_pkg.sv
// Shared definitions for the GPU parallel command bus master.
//
// Contents:
//   - Bus word widths for the command and data pins.
//   - Active-low level constants for chipSelect and outputEnable.
//   - The transaction state encoding.
//   - A small helper that sizes the shared phase counter.
package cmd_bus_pkg;

    localparam int CMD_WIDTH  = 16;
    localparam int DATA_WIDTH = 16;

    // chipSelect and outputEnable are both active-low on the bus.
    localparam logic CS_ACTIVE   = 1'b0;
    localparam logic CS_INACTIVE = 1'b1;
    localparam logic OE_ACTIVE   = 1'b0;
    localparam logic OE_INACTIVE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_READ   = 3'd4,
        ST_TURN   = 3'd5
    } bus_state_t;

    // Largest of the four phase lengths; the phase counter must hold it.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/bus_phase_timer.sv
// Loadable down-counter that times each bus phase.
//
// The controller loads (phase length - 1) on entry to a phase; terminal is
// high on the last cycle of that phase. Once at zero the counter stays there.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   load        load load_value this cycle
//   load_value  cycles remaining minus one for the phase being entered
//   terminal    counter is at zero (final cycle of the current phase)
module bus_phase_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             terminal
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign terminal = (count == '0);

endmodule

// File: rtl/command_bus_master.sv
// Host-side transmitter for the GPU parallel command bus.
//
// Converts single-word write/read requests into chipSelect / commandClk /
// outputEnable strobes with fixed setup, pulse and hold timing. Reads
// tristate the data pins, assert outputEnable, sample the returned word and
// report it on the response port.
//
// Ports:
//   clk, rst       clock (rising edge) and asynchronous active-low reset
//   reqValid/Ready request handshake; reqWrite selects write(1)/read(0)
//   reqCommand     command word, reqData write data (ignored for reads)
//   rspValid       one-cycle pulse when rspData holds a new read result
//   rspData        last read word, held until the next read completes
//   busy           transaction in progress
//   chipSelect     bus chip select, active-low
//   outputEnable   bus read enable, active-low
//   commandClk     command strobe, GPU latches on its rising edge
//   command        command pins
//   dataInOut      data pins, driven only during write phases
//
// Handshake: a request transfers on a rising clk edge where reqValid and
// reqReady are both high. reqReady is high exactly while the FSM is in IDLE
// (and rst is released); all request fields are captured at that edge, so the
// requester may change them freely afterwards. reqValid outside IDLE is
// ignored, nothing is queued.
module command_bus_master
    import cmd_bus_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1,
    parameter int READ_CYCLES  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [CMD_WIDTH-1:0]  reqCommand,
    input  logic [DATA_WIDTH-1:0] reqData,
    output logic                  rspValid,
    output logic [DATA_WIDTH-1:0] rspData,
    output logic                  busy,
    output logic                  chipSelect,
    output logic                  outputEnable,
    output logic                  commandClk,
    output logic [CMD_WIDTH-1:0]  command,
    inout  wire  [DATA_WIDTH-1:0] dataInOut
);

    localparam int MAX_PHASE = max4(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES, READ_CYCLES);
    localparam int CNT_W     = $clog2(MAX_PHASE) + 1;

    // Counter load values: the timer counts down to zero, so load length-1.
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_CYCLES - 1);

    bus_state_t            state;
    bus_state_t            next_state;
    logic                  accept;
    logic                  write_q;
    logic                  write_next;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  drive_q;
    logic                  drive_next;
    logic                  timer_load;
    logic [CNT_W-1:0]      timer_value;
    logic                  timer_done;
    logic                  read_sample;

    bus_phase_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .terminal   (timer_done)
    );

    assign reqReady    = rst && (state == ST_IDLE);
    assign accept      = reqValid && reqReady;
    assign busy        = (state != ST_IDLE);
    assign read_sample = (state == ST_READ) && timer_done;

    // The direction of the transaction being decided this cycle: on the
    // accept edge it comes straight from the request, otherwise from the
    // captured copy.
    assign write_next = accept ? reqWrite : write_q;

    // Next-state and timer-load logic. Every phase entry reloads the timer.
    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state  = ST_SETUP;
                    timer_load  = 1'b1;
                    timer_value = SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (timer_done) begin
                    next_state  = ST_STROBE;
                    timer_load  = 1'b1;
                    timer_value = PULSE_LOAD;
                end
            end
            ST_STROBE: begin
                if (timer_done) begin
                    next_state  = ST_HOLD;
                    timer_load  = 1'b1;
                    timer_value = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (timer_done) begin
                    if (write_q) begin
                        next_state = ST_IDLE;
                    end else begin
                        next_state  = ST_READ;
                        timer_load  = 1'b1;
                        timer_value = READ_LOAD;
                    end
                end
            end
            ST_READ: begin
                if (timer_done) begin
                    // TURN is a fixed single cycle; the load keeps the
                    // counter at a known value on entry.
                    next_state  = ST_TURN;
                    timer_load  = 1'b1;
                    timer_value = '0;
                end
            end
            ST_TURN: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Data pins are driven only through the write address/strobe/hold
    // phases. outputEnable is only active in READ, so the two can never
    // overlap.
    always_comb begin
        drive_next = 1'b0;
        if (write_next && ((next_state == ST_SETUP) || (next_state == ST_STROBE) ||
                           (next_state == ST_HOLD))) begin
            drive_next = 1'b1;
        end
    end

    // Bus outputs are registered from next_state so each pin changes in the
    // same cycle the FSM enters the corresponding phase, without glitches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            write_q      <= 1'b0;
            data_q       <= '0;
            command      <= '0;
            drive_q      <= 1'b0;
            chipSelect   <= CS_INACTIVE;
            outputEnable <= OE_INACTIVE;
            commandClk   <= 1'b0;
            rspValid     <= 1'b0;
            rspData      <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                write_q <= reqWrite;
                command <= reqCommand;
                data_q  <= reqData;
            end
            drive_q      <= drive_next;
            chipSelect   <= (next_state == ST_IDLE) ? CS_INACTIVE : CS_ACTIVE;
            outputEnable <= (next_state == ST_READ) ? OE_ACTIVE : OE_INACTIVE;
            commandClk   <= (next_state == ST_STROBE);
            // Sample on the last READ cycle; the pulse lands in TURN.
            rspValid     <= read_sample;
            if (read_sample) begin
                rspData <= dataInOut;
            end
        end
    end

    assign dataInOut = drive_q ? data_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_command_bus_master.sv
module tb_command_bus_master;

  localparam int S = 2;
  localparam int P = 2;
  localparam int H = 1;
  localparam int R = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default-parameter DUT ----------------
  logic        reqValid = 1'b0;
  logic        reqWrite = 1'b0;
  logic [15:0] reqCommand = '0;
  logic [15:0] reqData = '0;
  logic        reqReady, rspValid, busy, chipSelect, outputEnable, commandClk;
  logic [15:0] rspData, command;
  wire  [15:0] bus;
  logic [15:0] gpu_word = '0;

  // GPU model: returns gpu_word whenever the master enables a read.
  assign bus = (outputEnable == 1'b0) ? gpu_word : 16'hzzzz;

  command_bus_master #(
    .SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H), .READ_CYCLES(R)
  ) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady),
    .reqWrite(reqWrite), .reqCommand(reqCommand), .reqData(reqData),
    .rspValid(rspValid), .rspData(rspData), .busy(busy),
    .chipSelect(chipSelect), .outputEnable(outputEnable),
    .commandClk(commandClk), .command(command), .dataInOut(bus)
  );

  // ---------------- minimum-timing DUT ----------------
  logic        reqValid_f = 1'b0;
  logic        reqWrite_f = 1'b0;
  logic [15:0] reqCommand_f = '0;
  logic [15:0] reqData_f = '0;
  logic        reqReady_f, rspValid_f, busy_f, chipSelect_f, outputEnable_f, commandClk_f;
  logic [15:0] rspData_f, command_f;
  wire  [15:0] bus_f;

  assign bus_f = (outputEnable_f == 1'b0) ? gpu_word : 16'hzzzz;

  command_bus_master #(
    .SETUP_CYCLES(1), .PULSE_CYCLES(1), .HOLD_CYCLES(1), .READ_CYCLES(1)
  ) dut_fast (
    .clk(clk), .rst(rst), .reqValid(reqValid_f), .reqReady(reqReady_f),
    .reqWrite(reqWrite_f), .reqCommand(reqCommand_f), .reqData(reqData_f),
    .rspValid(rspValid_f), .rspData(rspData_f), .busy(busy_f),
    .chipSelect(chipSelect_f), .outputEnable(outputEnable_f),
    .commandClk(commandClk_f), .command(command_f), .dataInOut(bus_f)
  );

  // ---------------- scoreboard ----------------
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] sb_exp;
  logic [15:0] last_rsp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (rspValid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: got rspData %h with no read outstanding", rspData);
        end else begin
          sb_exp = exp_q.pop_front();
          check("rsp_data", {16'h0, rspData}, {16'h0, sb_exp});
        end
      end
      if (!outputEnable) check("no_drive_during_oe", {31'h0, dut.drive_q}, 32'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (!reqReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!reqReady) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got reqReady 0 expected 1 within 100 cycles");
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 after accept.
  task automatic start_req(input logic w, input logic [15:0] cmd, input logic [15:0] data);
    wait_ready();
    reqValid = 1'b1;
    reqWrite = w;
    reqCommand = cmd;
    reqData = data;
    @(negedge clk);
    reqValid = 1'b0;
    reqWrite = 1'($urandom_range(0, 1));
    reqCommand = 16'($urandom_range(0, 65535));
    reqData = 16'($urandom_range(0, 65535));
  endtask

  typedef struct {
    logic        write;
    logic [15:0] cmd;
    logic [15:0] data;
    logic [15:0] gpu;
    int          exp_cycles;
    logic [15:0] exp_rsp;
  } vec_t;

  vec_t vecs[6];

  task automatic run_txn(input int idx, input vec_t t);
    logic [6:0]  exp_ctl;
    logic        e_cs, e_oe, e_cclk, e_drive, e_busy, e_ready, e_rv;
    logic [15:0] e_rsp;
    int          nb;
    nb = S + P + H;
    gpu_word = t.gpu;
    if (!t.write) exp_q.push_back(t.gpu);
    start_req(t.write, t.cmd, t.data);
    for (int c = 1; c <= t.exp_cycles + 1; c++) begin
      e_cs    = (c <= t.exp_cycles) ? 1'b0 : 1'b1;
      e_cclk  = (c > S) && (c <= S + P);
      e_oe    = !(!t.write && (c > nb) && (c <= nb + R));
      e_drive = t.write && (c <= nb);
      e_busy  = (c <= t.exp_cycles);
      e_ready = !e_busy;
      e_rv    = !t.write && (c == t.exp_cycles);
      exp_ctl = {e_cs, e_oe, e_cclk, e_drive, e_busy, e_ready, e_rv};
      check($sformatf("ctl_v%0d_c%0d", idx, c),
            {25'h0, chipSelect, outputEnable, commandClk, dut.drive_q, busy, reqReady, rspValid},
            {25'h0, exp_ctl});
      if (c <= t.exp_cycles) check($sformatf("cmd_v%0d_c%0d", idx, c), {16'h0, command}, {16'h0, t.cmd});
      if (e_drive) check($sformatf("wdata_v%0d_c%0d", idx, c), {16'h0, bus}, {16'h0, t.data});
      e_rsp = (!t.write && c >= t.exp_cycles) ? t.gpu : last_rsp;
      check($sformatf("rspdata_v%0d_c%0d", idx, c), {16'h0, rspData}, {16'h0, e_rsp});
      @(negedge clk);
    end
    if (!t.write) last_rsp = t.gpu;
    check($sformatf("rsp_after_v%0d", idx), {16'h0, rspData}, {16'h0, t.exp_rsp});
  endtask

  // ---------------- test sequence ----------------
  logic        cs_hist[1:16];
  logic        prev_cclk;
  logic        drop_pending;
  int          rises;
  int          gap;
  int          first_hi;
  int          lows;
  logic [15:0] r;

  initial begin
    r = 16'($urandom_range(0, 65535));
    vecs[0] = '{1'b1, 16'h0012, 16'hBEEF, 16'h0000, 5, 16'h0000};
    vecs[1] = '{1'b0, 16'h8003, 16'h0000, 16'h5A5A, 9, 16'h5A5A};
    vecs[2] = '{1'b1, 16'h0034, 16'h1234, 16'h0000, 5, 16'h5A5A};
    vecs[3] = '{1'b0, 16'h8004, 16'h0000, r,        9, r};
    vecs[4] = '{1'b1, 16'h0056, 16'($urandom_range(0, 65535)), 16'h0000, 5, r};
    vecs[5] = '{1'b0, 16'h8005, 16'h0000, 16'hC3C3, 9, 16'hC3C3};

    // Reset state, checked while rst is held low.
    repeat (3) @(negedge clk);
    check("rst_ctl", {26'h0, chipSelect, outputEnable, commandClk, dut.drive_q, busy, reqReady},
          {26'h0, 6'b110000});
    check("rst_cmd", {16'h0, command}, 32'h0);
    check("rst_rsp", {15'h0, rspValid, rspData}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'h0, reqReady}, 32'h1);

    // Table-driven transactions with random idle gaps.
    for (int i = 0; i < 6; i++) begin
      run_txn(i, vecs[i]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Back-to-back writes with reqValid held high.
    wait_ready();
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqCommand = 16'h0001;
    reqData = 16'h1111;
    @(negedge clk);
    reqCommand = 16'h0002;
    reqData = 16'h2222;
    prev_cclk = 1'b0;
    rises = 0;
    drop_pending = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      cs_hist[c] = chipSelect;
      if (commandClk && !prev_cclk) rises++;
      prev_cclk = commandClk;
      if (c == 7) begin
        check("b2b_cmd2", {16'h0, command}, 32'h0002);
        check("b2b_data2", {16'h0, bus}, 32'h2222);
      end
      if (reqReady && reqValid) drop_pending = 1'b1;
      @(negedge clk);
      if (drop_pending) begin
        reqValid = 1'b0;
        drop_pending = 1'b0;
      end
    end
    check("b2b_strobes", rises, 2);
    first_hi = 0;
    lows = 0;
    for (int c = 1; c <= 16; c++) begin
      if (!cs_hist[c]) lows++;
      if (cs_hist[c] && first_hi == 0) first_hi = c;
    end
    gap = 0;
    if (first_hi != 0) begin
      for (int c = first_hi; c <= 16; c++) begin
        if (!cs_hist[c]) break;
        gap++;
      end
    end
    check("b2b_cs_gap", gap, 1);
    check("b2b_cs_low_total", lows, 10);

    // Reset asserted during STROBE of a write.
    start_req(1'b1, 16'h00AA, 16'h5555);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_strobe_pre", {31'h0, commandClk}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_ctl", {26'h0, chipSelect, outputEnable, commandClk, dut.drive_q, busy, reqReady},
          {26'h0, 6'b110000});
    check("rst_mid_cmd", {16'h0, command}, 32'h0);
    last_rsp = '0;
    check("rst_mid_rsp", {16'h0, rspData}, {16'h0, last_rsp});
    @(negedge clk);
    rst = 1'b1;
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqCommand = 16'h00BB;
    reqData = 16'h7777;
    @(negedge clk);
    reqValid = 1'b0;
    check("rst_reaccept", {15'h0, busy, chipSelect, command}, {15'h0, 1'b1, 1'b0, 16'h00BB});
    check("rst_reaccept_data", {16'h0, bus}, 32'h7777);
    repeat (6) @(negedge clk);
    check("rst_reaccept_done", {31'h0, busy}, 32'h0);

    // Minimum timing: 3-cycle write, read response 5 cycles after accept.
    reqValid_f = 1'b1;
    reqWrite_f = 1'b1;
    reqCommand_f = 16'h0101;
    reqData_f = 16'hA5A5;
    @(negedge clk);
    reqValid_f = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("fast_wr_c%0d", c), {30'h0, chipSelect_f, busy_f},
            (c <= 3) ? 32'h1 : 32'h2);
      @(negedge clk);
    end
    gpu_word = 16'h3C3C;
    reqValid_f = 1'b1;
    reqWrite_f = 1'b0;
    reqCommand_f = 16'h8101;
    @(negedge clk);
    reqValid_f = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("fast_rd_rv_c%0d", c), {31'h0, rspValid_f}, (c == 5) ? 32'h1 : 32'h0);
      check($sformatf("fast_rd_oe_c%0d", c), {31'h0, outputEnable_f}, (c == 4) ? 32'h0 : 32'h1);
      if (c == 5) check("fast_rd_data", {16'h0, rspData_f}, 32'h3C3C);
      @(negedge clk);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
